div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle 32-bit integer divider for the MIPS datapath; MULT's counterpart for DIV/DIVU.
//  Computes A_in / B_in (signed or unsigned) by restoring shift-subtract, one quotient bit per cycle.
//  Quotient goes to Lo and remainder to Hi, same Hi/Lo convention as the multiplier.
//  Control unit holds the FSM in a wait state until done pulses.
// PARAMETERS
//  WIDTH  32  operand/result width; the counter is sized $clog2(WIDTH)+1 bits
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  reset       in   1      asynchronous, active-low reset (0 = reset)
//  start       in   1      begin division; sampled only in IDLE
//  div_unsigned in  1      1 = DIVU (unsigned), 0 = DIV (signed two's complement)
//  A_in        in   WIDTH  dividend
//  B_in        in   WIDTH  divisor
//  busy        out  1      high from the accepting edge until done
//  done        out  1      one-cycle pulse: Hi/Lo/div_zero valid
//  div_zero    out  1      set with done when B_in==0; cleared at next accepted start
//  Hi          out  WIDTH  remainder
//  Lo          out  WIDTH  quotient
// BEHAVIOUR
//  - Reset (reset=0, any time, incl. mid-operation): state=IDLE, count=0, busy=0, done=0,
//    div_zero=0, Hi=0, Lo=0, internal regs cleared; operation in flight discarded.
//  - States: IDLE -> RUN -> FIX -> IDLE.
//  - IDLE, edge with start=1 (call it edge k): latch |A|, |B| (plain values if div_unsigned),
//    record sign_q = A[31]^B[31] and sign_r = A[31] (both 0 if unsigned); busy<=1; count<=0; div_zero<=0.
//    If B_in==0: no RUN; done<=1, div_zero<=1, busy stays 0, Hi/Lo unchanged, stay IDLE.
//  - RUN, edges k+1..k+32: {R,Q} <<= 1; if R >= M then R -= M, Q[0] = 1. R is WIDTH+1 bits
//    internally so unsigned compares never overflow. count++. At count==WIDTH-1, go to FIX.
//  - FIX, edge k+33: Lo <= sign_q ? -Q : Q; Hi <= sign_r ? -R : R; done<=1; busy<=0; -> IDLE.
//    done is high for exactly the cycle after edge k+33. Latency is 34 edges from start.
//  - done self-clears the next cycle. Hi/Lo hold their values until the next completed division.
//  - start while busy is ignored; it is not queued. start held high re-triggers a division
//    on the first IDLE edge after done.
//  - A_in, B_in and div_unsigned are sampled only at edge k; later changes have no effect.
//  - Signed semantics truncate toward zero; remainder takes the dividend's sign.
//  - Overflow case (signed 0x80000000 / 0xFFFFFFFF): Lo=0x80000000, Hi=0, no flag.
//  - Unsigned 0x80000000 operands are valid magnitudes; no sign handling is applied.
// TESTING
//  1 DIV 7/2 -> at cycle k+34: done=1, Lo=3, Hi=1, div_zero=0; busy high cycles k+1..k+33
//  2 DIV -7/2 (0xFFFFFFF9/2) -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV 7/-2 -> Lo=0xFFFFFFFD, Hi=1
//  3 DIVU 0xFFFFFFFF/16 -> Lo=0x0FFFFFFF, Hi=0xF; DIV on the same operands -> Lo=0, Hi=0xFFFFFFFF
//  4 B_in=0, prior Hi/Lo=0x1234/0x5678 -> done and div_zero at cycle k+1, Hi/Lo unchanged, busy=0
//  5 DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0; 0/5 -> Lo=0, Hi=0
//  6 reset=0 at cycle k+10, then start 100/7 with start also pulsed mid-RUN -> all outputs 0
//    during reset, a single done, Lo=14, Hi=2

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring shift-subtract divider for DIV/DIVU.
// Quotient is returned on Lo and remainder on Hi. A division takes 34 edges
// from the accepting edge to the done pulse. A zero divisor completes
// immediately with div_zero set.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             div_unsigned,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             sign_q, sign_r;

   logic             a_neg, b_neg, b_zero, accept;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_sh;
   logic             ge;
   logic [WIDTH-1:0] diff, rem_nx, quo_nx;

   // Operand magnitudes and one restoring step.
   // The shifted remainder is one bit wider so the compare never overflows.
   always_comb begin
      a_neg  = ~div_unsigned & A_in[WIDTH-1];
      b_neg  = ~div_unsigned & B_in[WIDTH-1];
      a_mag  = a_neg ? -A_in : A_in;
      b_mag  = b_neg ? -B_in : B_in;
      b_zero = (B_in == '0);
      accept = (state == S_IDLE) && start;
      rem_sh = {rem, quo[WIDTH-1]};
      ge     = (rem_sh >= {1'b0, dvs});
      diff   = rem_sh[WIDTH-1:0] - dvs;
      rem_nx = ge ? diff : rem_sh[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], ge};
   end

   // Next-state logic for the IDLE -> RUN -> FIX sequence.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start && !b_zero) state_nx = S_RUN;
         S_RUN:   if (count == CW'(WIDTH - 1)) state_nx = S_FIX;
         S_FIX:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Datapath, status flags and result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         Hi       <= '0;
         Lo       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  count    <= '0;
                  rem      <= '0;
                  quo      <= a_mag;
                  dvs      <= b_mag;
                  sign_q   <= a_neg ^ b_neg;
                  sign_r   <= a_neg;
                  busy     <= ~b_zero;
                  done     <= b_zero;
                  div_zero <= b_zero;
               end
            end
            S_RUN: begin
               rem   <= rem_nx;
               quo   <= quo_nx;
               count <= count + 1'b1;
            end
            S_FIX: begin
               Lo   <= sign_q ? -quo : quo;
               Hi   <= sign_r ? -rem : rem;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with hand-computed results.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        div_unsigned;
   logic [31:0] A_in, B_in;
   logic        busy, done, div_zero;
   logic [31:0] Hi, Lo;

   int total = 0;
   int bad   = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .div_unsigned (div_unsigned),
      .A_in         (A_in),
      .B_in         (B_in),
      .busy         (busy),
      .done         (done),
      .div_zero     (div_zero),
      .Hi           (Hi),
      .Lo           (Lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present operands and start; returns #1 after the accepting edge.
   // Operands are scrambled afterwards to show they are only sampled once.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic u, input logic hold);
      @(negedge clk);
      A_in = a; B_in = b; div_unsigned = u; start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      A_in = ~a; B_in = b ^ 32'h0000_0005; div_unsigned = ~u;
   endtask

   // Counts edges until done is seen, and how many of those samples had busy.
   task automatic wait_done(output int cyc, output int bcyc);
      cyc = 0; bcyc = 0;
      while (!done && cyc < 60) begin
         if (busy) bcyc++;
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) check("done_timeout", 32'(cyc), 32'd33);
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic u,
                      input logic [31:0] elo, input logic [31:0] ehi);
      int cyc, bcyc;
      launch(a, b, u, 1'b0);
      wait_done(cyc, bcyc);
      check({tag, "_lo"}, Lo, elo);
      check({tag, "_hi"}, Hi, ehi);
      check({tag, "_dz"}, 32'(div_zero), 32'd0);
      check({tag, "_lat"}, 32'(cyc), 32'd33);
      check({tag, "_busy"}, 32'(bcyc), 32'd33);
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int cyc, bcyc, dcnt;
      logic [31:0] clo, chi;
      reset = 1'b0; start = 1'b0; div_unsigned = 1'b0; A_in = '0; B_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dz", 32'(div_zero), 32'd0);
      check("rst_hi", Hi, 32'd0);
      check("rst_lo", Lo, 32'd0);
      @(negedge clk); reset = 1'b1;

      run("div7_2",   32'd7,          32'd2,          1'b0, 32'd3,          32'd1);
      run("divm7_2",  32'hFFFF_FFF9,  32'd2,          1'b0, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
      run("div7_m2",  32'd7,          32'hFFFF_FFFE,  1'b0, 32'hFFFF_FFFD,  32'd1);
      run("divu_ff",  32'hFFFF_FFFF,  32'd16,         1'b1, 32'h0FFF_FFFF,  32'h0000_000F);
      run("div_ff",   32'hFFFF_FFFF,  32'd16,         1'b0, 32'd0,          32'hFFFF_FFFF);
      run("div_ovf",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0);
      run("div0_5",   32'd0,          32'd5,          1'b0, 32'd0,          32'd0);
      run("divmm",    32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b0, 32'd14,         32'hFFFF_FFFE);
      run("divu_8",   32'h8000_0000,  32'h8000_0000,  1'b1, 32'd1,          32'd0);
      run("divu_f1",  32'hFFFF_FFFF,  32'd1,          1'b1, 32'hFFFF_FFFF,  32'd0);

      // Seed Hi/Lo with 0x1234/0x5678, then divide by zero.
      run("seed",     32'h5678_1234,  32'h0001_0000,  1'b1, 32'h0000_5678,  32'h0000_1234);
      launch(32'd99, 32'd0, 1'b0, 1'b0);
      check("dz_done", 32'(done), 32'd1);
      check("dz_flag", 32'(div_zero), 32'd1);
      check("dz_busy", 32'(busy), 32'd0);
      check("dz_hi", Hi, 32'h0000_1234);
      check("dz_lo", Lo, 32'h0000_5678);
      @(posedge clk); #1;
      check("dz_pulse", 32'(done), 32'd0);
      check("dz_hold", 32'(div_zero), 32'd1);
      // div_zero clears on the next accepted start.
      launch(32'd9, 32'd3, 1'b0, 1'b0);
      check("dz_clear", 32'(div_zero), 32'd0);
      wait_done(cyc, bcyc);
      check("after_dz_lo", Lo, 32'd3);

      // Start held high re-triggers on the first IDLE edge after done.
      launch(32'd20, 32'd6, 1'b1, 1'b1);
      A_in = 32'd45; B_in = 32'd4; div_unsigned = 1'b1;
      wait_done(cyc, bcyc);
      check("rt1_lo", Lo, 32'd3);
      check("rt1_hi", Hi, 32'd2);
      @(posedge clk); #1;
      start = 1'b0;
      check("rt_busy", 32'(busy), 32'd1);
      wait_done(cyc, bcyc);
      check("rt2_lo", Lo, 32'd11);
      check("rt2_hi", Hi, 32'd1);
      check("rt2_lat", 32'(cyc), 32'd33);

      // Reset mid-run, then a division with a stray start pulse while busy.
      launch(32'd50, 32'd3, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      #1;
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_done", 32'(done), 32'd0);
      check("mr_dz", 32'(div_zero), 32'd0);
      check("mr_hi", Hi, 32'd0);
      check("mr_lo", Lo, 32'd0);
      @(posedge clk); #1;
      check("mr_busy2", 32'(busy), 32'd0);
      check("mr_lo2", Lo, 32'd0);
      @(negedge clk); reset = 1'b1;
      launch(32'd100, 32'd7, 1'b0, 1'b0);
      A_in = 32'd999; B_in = 32'd1;
      dcnt = 0; clo = '0; chi = '0;
      for (int i = 0; i < 60; i++) begin
         if (i == 15) start = 1'b1;
         if (i == 16) start = 1'b0;
         @(posedge clk); #1;
         if (done) begin
            dcnt++;
            clo = Lo;
            chi = Hi;
         end
      end
      check("mr_dcnt", 32'(dcnt), 32'd1);
      check("mr_lo14", clo, 32'd14);
      check("mr_hi2", chi, 32'd2);
      check("mr_idle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
